// File: rtl/gpio_out_arbiter_if.sv
// rtl/gpio_out_arbiter_if.sv - requester/GPIO bundle for the GPIO output arbiter
interface gpio_out_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int GPIO_W  = 32
);
    logic [NUM_REQ-1:0]        REQ;
    logic [NUM_REQ*GPIO_W-1:0] WDATA;
    logic [NUM_REQ*GPIO_W-1:0] WMASK;
    logic [NUM_REQ-1:0]        GNT;
    logic [NUM_REQ-1:0]        ACK;
    logic                      BUSY;
    logic [GPIO_W-1:0]         GPIO_IN;
    logic [GPIO_W-1:0]         GPIO_IN_SYNC;
    logic [GPIO_W-1:0]         GPIO_OUT;

    modport master (
        output REQ, WDATA, WMASK, GPIO_IN,
        input  GNT, ACK, BUSY, GPIO_IN_SYNC, GPIO_OUT
    );

    modport slave (
        input  REQ, WDATA, WMASK, GPIO_IN,
        output GNT, ACK, BUSY, GPIO_IN_SYNC, GPIO_OUT
    );
endinterface

// File: rtl/gpio_out_arbiter.sv
// rtl/gpio_out_arbiter.sv - round-robin masked-write arbiter for the shared GPIO output register
module gpio_out_arbiter #(
    parameter int                NUM_REQ     = 4,
    parameter int                GPIO_W      = 32,
    parameter int                HOLD_CYCLES = 0,
    parameter logic [GPIO_W-1:0] RESET_VALUE = '0
) (
    input  logic               CLK0,
    input  logic               DEVRST,
    gpio_out_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       ptr, win, win_q;
    logic [IW:0]         pos;
    logic                found;
    logic [NUM_REQ-1:0]  eff, gnt_d, ack_d, gnt_q, ack_q;
    logic [GPIO_W-1:0]   sel_data, sel_mask, data_q, mask_q, gpio_q;
    logic [GPIO_W-1:0]   sync1, sync2;
    logic [7:0]          hold_cnt;

    // A requester still asserting REQ in its ACK cycle must not win again.
    assign eff = bus.REQ & ~ack_q;

    always_comb begin
        win   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(NUM_REQ))
                pos = pos - (IW+1)'(NUM_REQ);
            if (!found && eff[pos[IW-1:0]]) begin
                found = 1'b1;
                win   = pos[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_mask = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == IW'(k)) begin
                sel_data = bus.WDATA[k*GPIO_W +: GPIO_W];
                sel_mask = bus.WMASK[k*GPIO_W +: GPIO_W];
            end
        end
    end

    always_ff @(posedge CLK0 or posedge DEVRST) begin
        if (DEVRST) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = APPLY;
            APPLY:   state_nxt = (HOLD_CYCLES > 0) ? HOLD : IDLE;
            HOLD:    if (hold_cnt <= 8'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_d    = '0;
        ack_d    = '0;
        bus.BUSY = (state != IDLE);
        if (state == IDLE && found)
            gnt_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
        if (state == APPLY)
            ack_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
    end

    always_ff @(posedge CLK0 or posedge DEVRST) begin
        if (DEVRST) begin
            gnt_q    <= '0;
            ack_q    <= '0;
            win_q    <= '0;
            ptr      <= '0;
            data_q   <= '0;
            mask_q   <= '0;
            hold_cnt <= '0;
            gpio_q   <= RESET_VALUE;
        end else begin
            gnt_q <= gnt_d;
            ack_q <= ack_d;
            if (state == IDLE && found) begin
                win_q  <= win;
                data_q <= sel_data;
                mask_q <= sel_mask;
            end
            if (state == APPLY) begin
                gpio_q   <= (gpio_q & ~mask_q) | (data_q & mask_q);
                ptr      <= (win_q == IW'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
                hold_cnt <= 8'(HOLD_CYCLES);
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge CLK0 or posedge DEVRST) begin
        if (DEVRST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.GPIO_IN;
            sync2 <= sync1;
        end
    end

    assign bus.GNT          = gnt_q;
    assign bus.ACK          = ack_q;
    assign bus.GPIO_OUT     = gpio_q;
    assign bus.GPIO_IN_SYNC = sync2;
endmodule

// File: tb/tb_gpio_out_arbiter.sv
// tb/tb_gpio_out_arbiter.sv - self-checking bench for gpio_out_arbiter
module tb_gpio_out_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic CLK0 = 1'b0;
    logic DEVRST;

    gpio_out_arbiter_if #(.NUM_REQ(N), .GPIO_W(W)) a_if();
    gpio_out_arbiter_if #(.NUM_REQ(N), .GPIO_W(W)) b_if();

    gpio_out_arbiter #(.NUM_REQ(N), .GPIO_W(W), .HOLD_CYCLES(0), .RESET_VALUE(32'hA5A5_0000))
        dut_a (.CLK0(CLK0), .DEVRST(DEVRST), .bus(a_if.slave));
    gpio_out_arbiter #(.NUM_REQ(N), .GPIO_W(W), .HOLD_CYCLES(3), .RESET_VALUE(32'h0000_0000))
        dut_b (.CLK0(CLK0), .DEVRST(DEVRST), .bus(b_if.slave));

    always #5 CLK0 = ~CLK0;

    typedef struct {
        logic [N-1:0] ack;
        logic [W-1:0] gpio;
    } exp_t;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
        logic [W-1:0] mask;
        logic [W-1:0] exp_out;
    } vec_t;

    exp_t         sb[$];
    vec_t         tbl[5];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] model;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK0);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] d, input logic [W-1:0] m);
        a_if.REQ[i]          = v;
        a_if.WDATA[i*W +: W] = d;
        a_if.WMASK[i*W +: W] = m;
    endtask

    task automatic push(input int i, input logic [W-1:0] g);
        exp_t e;
        e.ack  = N'(1) << i;
        e.gpio = g;
        sb.push_back(e);
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] d,
                                           input logic [W-1:0] m);
        return (o & ~m) | (d & m);
    endfunction

    // Scoreboard: every ACK on DUT A must match the next queued write.
    always begin
        @(posedge CLK0);
        #1;
        if (a_if.ACK != '0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got %b expected none", a_if.ACK);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_ack", W'(a_if.ACK), W'(e.ack));
                check("sb_gpio_out", a_if.GPIO_OUT, e.gpio);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        int g;
        bit done;
        int ack0_c, ack2_c, gnt2_c;
        logic busy_h[16];

        a_if.REQ = '0; a_if.WDATA = '0; a_if.WMASK = '0; a_if.GPIO_IN = 32'hFFFF_FFFF;
        b_if.REQ = '0; b_if.WDATA = '0; b_if.WMASK = '0; b_if.GPIO_IN = '0;
        DEVRST = 1'b1;
        repeat (2) tick;
        check("rst_gpio_out", a_if.GPIO_OUT, 32'hA5A5_0000);
        check("rst_gnt", W'(a_if.GNT), '0);
        check("rst_ack", W'(a_if.ACK), '0);
        check("rst_busy", W'(a_if.BUSY), '0);
        check("rst_sync", a_if.GPIO_IN_SYNC, '0);
        check("rst_gpio_out_b", b_if.GPIO_OUT, '0);

        DEVRST = 1'b0;
        a_if.GPIO_IN = 32'h1234_5678;
        tick;
        check("sync_stage1", a_if.GPIO_IN_SYNC, '0);
        tick;
        check("sync_stage2", a_if.GPIO_IN_SYNC, 32'h1234_5678);

        tbl[0] = '{1, 32'hFFFF_FFFF, 32'h0000_00F0, 32'hA5A5_00F0};
        tbl[1] = '{0, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_00F0};
        tbl[2] = '{2, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_00F0};
        tbl[3] = '{2, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_00F1};
        tbl[4] = '{3, 32'h1234_5678, 32'h0F0F_0F0F, 32'h8204_06F8};
        for (int v = 0; v < 5; v++) begin
            set_req(tbl[v].idx, 1'b1, tbl[v].data, tbl[v].mask);
            push(tbl[v].idx, tbl[v].exp_out);
            tick;
            check("vec_gnt", W'(a_if.GNT), W'(N'(1) << tbl[v].idx));
            check("vec_busy", W'(a_if.BUSY), 32'd1);
            tick;
            check("vec_gnt_drop", W'(a_if.GNT), '0);
            tick;
            check("vec_no_regrant", W'(a_if.GNT), '0);
            set_req(tbl[v].idx, 1'b0, '0, '0);
        end
        model = tbl[4].exp_out;

        // Round robin with all four requesters asserting continuously.
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) set_req(i, 1'b1, W'(i), 32'h0000_000F);
        for (int i = 0; i < 5; i++) begin
            model = merge(model, W'(order[i]), 32'h0000_000F);
            push(order[i], model);
        end
        g = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick;
            if (a_if.GNT != '0) begin
                if (g < 5) check("rr_grant", W'(a_if.GNT), W'(N'(1) << order[g]));
                g++;
            end
            if (g == 5 && a_if.ACK[0]) begin
                a_if.REQ = '0;
                done = 1'b1;
            end
        end
        tick;
        check("rr_count", g, 5);
        check("rr_idle_gnt", W'(a_if.GNT), '0);

        // Late REQ during APPLY, and REQ withdrawn after its grant.
        set_req(0, 1'b1, 32'h0000_AA00, 32'h0000_FF00);
        model = merge(model, 32'h0000_AA00, 32'h0000_FF00);
        push(0, model);
        tick;
        check("late_gnt0", W'(a_if.GNT), 32'b0001);
        set_req(0, 1'b0, '0, '0);
        set_req(3, 1'b1, 32'h5000_0000, 32'hF000_0000);
        model = merge(model, 32'h5000_0000, 32'hF000_0000);
        push(3, model);
        tick;
        check("late_apply_gnt", W'(a_if.GNT), '0);
        tick;
        check("late_gnt3", W'(a_if.GNT), 32'b1000);
        tick;
        set_req(3, 1'b0, '0, '0);
        tick;
        check("late_idle_gnt", W'(a_if.GNT), '0);

        // Reset during APPLY aborts the write.
        set_req(2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick;
        check("abort_gnt", W'(a_if.GNT), 32'b0100);
        DEVRST = 1'b1;
        set_req(2, 1'b0, '0, '0);
        #1;
        check("abort_gpio_out", a_if.GPIO_OUT, 32'hA5A5_0000);
        check("abort_gnt_clr", W'(a_if.GNT), '0);
        check("abort_busy", W'(a_if.BUSY), '0);
        tick;
        tick;
        DEVRST = 1'b0;
        model = 32'hA5A5_0000;
        set_req(1, 1'b1, 32'h0000_0003, 32'h0000_000F);
        set_req(3, 1'b1, 32'h0000_0030, 32'h0000_00F0);
        model = merge(model, 32'h0000_0003, 32'h0000_000F);
        push(1, model);
        model = merge(model, 32'h0000_0030, 32'h0000_00F0);
        push(3, model);
        tick;
        check("post_rst_gnt1", W'(a_if.GNT), 32'b0010);
        tick;
        set_req(1, 1'b0, '0, '0);
        tick;
        check("post_rst_gnt3", W'(a_if.GNT), 32'b1000);
        tick;
        set_req(3, 1'b0, '0, '0);
        tick;
        check("post_rst_idle", W'(a_if.GNT), '0);

        // Hold time on DUT B (HOLD_CYCLES = 3).
        b_if.WDATA[0*W +: W] = 32'h0000_0001; b_if.WMASK[0*W +: W] = 32'h0000_0001;
        b_if.WDATA[2*W +: W] = 32'h0000_0004; b_if.WMASK[2*W +: W] = 32'h0000_0004;
        b_if.REQ = 4'b0101;
        ack0_c = -1; ack2_c = -1; gnt2_c = -1;
        for (int c = 0; c < 16; c++) begin
            tick;
            busy_h[c] = b_if.BUSY;
            if (b_if.ACK[0] && ack0_c < 0) begin ack0_c = c; b_if.REQ[0] = 1'b0; end
            if (b_if.ACK[2] && ack2_c < 0) begin ack2_c = c; b_if.REQ[2] = 1'b0; end
            if (b_if.GNT[2] && gnt2_c < 0) gnt2_c = c;
        end
        check("hold_ack0_cycle", ack0_c, 1);
        check("hold_busy_c2", W'(busy_h[2]), 32'd1);
        check("hold_busy_c3", W'(busy_h[3]), 32'd1);
        check("hold_busy_c4", W'(busy_h[4]), 32'd0);
        check("hold_gnt2_cycle", gnt2_c, 5);
        check("hold_ack_spacing", ack2_c - ack0_c, 5);
        check("hold_gpio_out", b_if.GPIO_OUT, 32'h0000_0005);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
